// File: rtl/control_fsm_if.sv
// control_fsm_if: run/instruction request and decoder-facing outputs of the
// control_fsm instruction sequencer, bundled so both sides share widths.
interface control_fsm_if #(
    parameter int INSTR_W = 23,
    parameter int CNT_W   = 16
);
    logic               i_run;
    logic [INSTR_W-1:0] i_instr_in;
    logic [4:0]         o_state;
    logic [INSTR_W-1:0] o_ir;
    logic               o_alu_sub;
    logic               o_busy;
    logic               o_done;
    logic               o_err;
    logic [CNT_W-1:0]   o_instr_count;

    // Requester side: issues instructions, observes the sequencer.
    modport master (
        output i_run, i_instr_in,
        input  o_state, o_ir, o_alu_sub, o_busy, o_done, o_err, o_instr_count
    );

    // Sequencer side.
    modport slave (
        input  i_run, i_instr_in,
        output o_state, o_ir, o_alu_sub, o_busy, o_done, o_err, o_instr_count
    );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: instruction sequencer for the simple CPU datapath.
// Latches an instruction on run (when idle) and steps the 5-bit control
// state through its execution cycles; state/ir feed the output decoder.
// Optional retire counter enabled by defining CONTROL_FSM_PERFCNT_EN;
// otherwise o_instr_count is tied to zero and no counter flops exist.
module control_fsm #(
    parameter int INSTR_W = 23,
    parameter int CNT_W   = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    control_fsm_if.slave   bus
);
    // State codes are fixed: the downstream decoder depends on them.
    typedef enum logic [4:0] {
        S_IDLE    = 5'b00000,
        S_LOAD    = 5'b00001,
        S_MOV     = 5'b00010,
        S_ARITH_A = 5'b00011,
        S_ARITH_G = 5'b00100,
        S_ARITH_W = 5'b00101
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;

    state_t             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic               r_alu_sub;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    state_t             w_next_state;
    logic               w_accept;
    logic               w_arith;
    logic               w_illegal;
    logic               w_done_next;
    logic [2:0]         w_opcode;

    assign w_opcode = bus.i_instr_in[INSTR_W-1:INSTR_W-3];

    // Next-state logic: acceptance/opcode branch in IDLE, fixed walk otherwise.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_arith      = 1'b0;
        w_illegal    = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_run) begin
                    w_accept = 1'b1;
                    case (w_opcode)
                        OP_LOAD: w_next_state = S_LOAD;
                        OP_MOV:  w_next_state = S_MOV;
                        OP_ADD, OP_SUB: begin
                            w_next_state = S_ARITH_A;
                            w_arith      = 1'b1;
                        end
                        default: begin
                            // Illegal opcode: stay idle and flag it.
                            w_next_state = S_IDLE;
                            w_illegal    = 1'b1;
                        end
                    endcase
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD, S_MOV: begin
                w_next_state = S_IDLE;
                w_done_next  = 1'b1;
            end
            S_ARITH_A: w_next_state = S_ARITH_G;
            S_ARITH_G: w_next_state = S_ARITH_W;
            S_ARITH_W: begin
                w_next_state = S_IDLE;
                w_done_next  = 1'b1;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register plus registered busy/done/err status.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= w_done_next;
            r_err   <= w_illegal;
        end
    end

    // Instruction register and ALU select; both change only on acceptance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ir      <= {INSTR_W{1'b0}};
            r_alu_sub <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ir <= bus.i_instr_in;
            end
            if (w_arith) begin
                r_alu_sub <= w_opcode[0];
            end
        end
    end

`ifdef CONTROL_FSM_PERFCNT_EN
    logic [CNT_W-1:0] r_instr_count;

    // Retire counter: counts completions, wraps naturally at 2^CNT_W.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr_count <= {CNT_W{1'b0}};
        end else if (w_done_next) begin
            r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    assign bus.o_instr_count = r_instr_count;
`else
    assign bus.o_instr_count = {CNT_W{1'b0}};
`endif

    assign bus.o_state   = r_state;
    assign bus.o_ir      = r_ir;
    assign bus.o_alu_sub = r_alu_sub;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_err     = r_err;
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed + randomized checks of control_fsm against a
// queue-based reference model of the instruction execution timeline.
module tb_control_fsm;
    localparam int INSTR_W = 23;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    control_fsm_if #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

    control_fsm #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: remaining execution states of the current instruction.
    logic [4:0]         exp_q[$];
    logic [4:0]         m_state;
    logic [INSTR_W-1:0] m_ir;
    logic               m_alu_sub;
    logic               m_done;
    logic               m_err;
    int                 m_count;

    task automatic model_reset();
        exp_q.delete();
        m_state = 5'd0; m_ir = '0; m_alu_sub = 1'b0;
        m_done = 1'b0; m_err = 1'b0; m_count = 0;
    endtask

    task automatic model_edge(input logic run, input logic [INSTR_W-1:0] instr);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                m_done = 1'b1;
`ifdef CONTROL_FSM_PERFCNT_EN
                m_count = (m_count + 1) % (1 << CNT_W);
`endif
            end
        end else if (run) begin
            m_ir = instr;
            case (instr[INSTR_W-1:INSTR_W-3])
                3'd0: exp_q.push_back(5'd1);
                3'd1: exp_q.push_back(5'd2);
                3'd2, 3'd3: begin
                    exp_q.push_back(5'd3);
                    exp_q.push_back(5'd4);
                    exp_q.push_back(5'd5);
                    m_alu_sub = instr[INSTR_W-3];
                end
                default: m_err = 1'b1;
            endcase
        end
        m_state = (exp_q.size() > 0) ? exp_q[0] : 5'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(bus.o_state), 32'(m_state));
        chk({tag, ".ir"},    32'(bus.o_ir), 32'(m_ir));
        chk({tag, ".alu_sub"}, 32'(bus.o_alu_sub), 32'(m_alu_sub));
        chk({tag, ".busy"},  32'(bus.o_busy), 32'(m_state != 5'd0));
        chk({tag, ".done"},  32'(bus.o_done), 32'(m_done));
        chk({tag, ".err"},   32'(bus.o_err), 32'(m_err));
        chk({tag, ".count"}, 32'(bus.o_instr_count), 32'(m_count));
    endtask

    task automatic step(input string tag, input logic run, input logic [INSTR_W-1:0] instr);
        @(negedge clk);
        bus.i_run      = run;
        bus.i_instr_in = instr;
        @(posedge clk);
        model_edge(run, instr);
        #1;
        check_all(tag);
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input logic [3:0] dst,
                                              input logic [3:0] src);
        logic [11:0] low;
        low = 12'($urandom);
        return {op, dst, src, low};
    endfunction

    initial begin
        logic [INSTR_W-1:0] ins;
        bus.i_run      = 1'b0;
        bus.i_instr_in = '0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Load with dest 3: LOAD next cycle, then done back in IDLE.
        ins = mk(3'b000, 4'd3, 4'd0);
        step("load_acc", 1'b1, ins);
        chk("load_state", 32'(bus.o_state), 32'h1);
        step("load_done", 1'b0, '0);
        chk("load_done_pulse", 32'(bus.o_done), 32'h1);

        // Sub src 2 dest 5, with run held during execution (ignored).
        step("sub_a", 1'b1, mk(3'b011, 4'd5, 4'd2));
        step("sub_g", 1'b1, mk(3'b010, 4'd1, 4'd1));
        chk("sub_g_state", 32'(bus.o_state), 32'h4);
        step("sub_w", 1'b1, mk(3'b001, 4'd7, 4'd7));
        step("sub_done", 1'b1, mk(3'b001, 4'd7, 4'd7));
        chk("sub_done_pulse", 32'(bus.o_done), 32'h1);
        // Accepted in the done cycle.
        step("b2b_acc", 1'b1, mk(3'b010, 4'd9, 4'd8));
        chk("b2b_state", 32'(bus.o_state), 32'h3);
        step("add_g", 1'b0, '0);
        step("add_w", 1'b0, '0);
        step("add_done", 1'b0, '0);

        // Illegal opcode, then a mov accepted in the err cycle.
        step("illegal", 1'b1, mk(3'b110, 4'd2, 4'd2));
        chk("illegal_err", 32'(bus.o_err), 32'h1);
        step("mov_after_err", 1'b1, mk(3'b001, 4'd4, 4'd6));
        step("mov_done", 1'b0, '0);

        // Asynchronous reset during ARITH_G.
        step("rst_a", 1'b1, mk(3'b011, 4'd1, 4'd2));
        step("rst_g", 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b0, '0);
        step("post_rst2", 1'b0, '0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            ins = mk(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
            step("rand", ($urandom_range(0, 3) != 0), ins);
        end

        // Retire 2^CNT_W instructions from a clean reset: counter wraps to 0.
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < (1 << CNT_W); i++) begin
            step("wrap_acc", 1'b1, mk(3'b000, 4'($urandom), 4'($urandom)));
            step("wrap_done", 1'b0, '0);
        end
        chk("wrap_zero", 32'(bus.o_instr_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
# control_fsm

Instruction sequencer for the simple CPU datapath. Accepts one instruction word on a `run` request, latches it into the instruction register, and steps a 5-bit control state through the execution cycles of that instruction. `state` and `ir` feed the output-signal decoder directly downstream, which turns them into tri-state bus selects, register write enables and PC stepping. Also drives the ALU add/sub select and a completion pulse.

## Interface
- `INSTR_W`, 23: instruction width. Opcode is `ir[INSTR_W-1:INSTR_W-3]`; dest field `ir[19:16]` and src field `ir[15:12]` are passed through untouched.
- `CNT_W`, 16: retire-counter width (only used when `CONTROL_FSM_PERFCNT_EN` is defined).

Ports, clock and reset first:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  start request; sampled only when idle.
- `instr_in`  in  INSTR_W  instruction word; valid while `run`=1.
- `state`  out  5  control state to the decoder.
- `ir`  out  INSTR_W  latched instruction to the decoder.
- `alu_sub`  out  1  ALU select: 1=subtract, 0=add.
- `busy`  out  1  1 whenever `state` != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle illegal-opcode pulse.
- `instr_count`  out  CNT_W  retired-instruction count (macro-gated).

## Operation
State codes, fixed because the decoder depends on them:
- IDLE=5'b00000
- LOAD=5'b00001
- MOV=5'b00010
- ARITH_A=5'b00011 (src → A register)
- ARITH_G=5'b00100 (src2 → ALU, result → G)
- ARITH_W=5'b00101 (G → dest)

Opcodes: 000 load, 001 mov, 010 add, 011 sub, 100–111 illegal.

Transitions:
- IDLE with `run`=1: `ir`←`instr_in`, then branch on the opcode of `instr_in`.
  - load → LOAD
  - mov → MOV
  - add/sub → ARITH_A
  - illegal → stay IDLE and pulse `err` next cycle.
- IDLE with `run`=0: hold; `ir` holds.
- LOAD → IDLE; MOV → IDLE.
- ARITH_A → ARITH_G → ARITH_W → IDLE.
- `run` while `busy`=1 is ignored: no queuing, `ir` unchanged.
- `alu_sub` is registered. It is set to `instr_in` opcode bit0 when an arith instruction is accepted, and holds until the next accepted arith instruction.

Outputs and counter:
- `done`: registered. Asserted for exactly one cycle after the last execution state, i.e. the first cycle back in IDLE.
- `err`: registered. One cycle, in the cycle after an illegal instruction is accepted; `done` stays 0.
- No other outputs change in IDLE except on acceptance.
- `instr_count` increments with each `done` and wraps at 2^CNT_W−1 → 0. Illegal instructions are not counted.

Reset values (async, immediate): `state`=IDLE, `ir`=0, `alu_sub`=0, `busy`=0, `done`=0, `err`=0, `instr_count`=0. A reset mid-instruction abandons it, with no `done` for that instruction.

## Timing
Edge k samples `run`=1 in IDLE.
- Load/mov: LOAD or MOV during cycle k+1; IDLE with `done`=1 in cycle k+2.
- Arith: ARITH_A at k+1, ARITH_G at k+2, ARITH_W at k+3; `done`=1 in k+4.
- Back-to-back: `run`=1 during the `done` cycle is accepted (state is IDLE). Sustained throughput is 1 instruction per 2 cycles (load/mov) or per 4 cycles (arith).
- Illegal: `err`=1 in k+1, state IDLE; a new `run` in k+1 is accepted.
- `ir` is stable from k+1 until the next acceptance.
- Reset released between edges: the first edge after deassertion samples `run` normally.

## Configuration
- `CONTROL_FSM_PERFCNT_EN` defined: the `instr_count` register exists and counts as above.
- Not defined: no counter flops; `instr_count` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then `run`=1 with opcode 000, dest 4'd3 → state 00001 next cycle, `ir`=`instr_in`; `done`=1 one cycle later with state 00000; `instr_count`=1.
- Opcode 011, src 4'd2, dest 4'd5 → states 00011, 00100, 00101 on consecutive cycles, `alu_sub`=1 throughout; `done` in the 4th cycle.
- `run` held high during ARITH_G with different `instr_in` → ignored; `ir` unchanged, sequence completes normally; new instruction accepted in the `done` cycle.
- Opcode 110 → state stays 00000, `err`=1 for one cycle, `done`=0, `instr_count` unchanged.
- Assert `rst` asynchronously during ARITH_G → all outputs at reset values before the next edge; no `done` pulse after release.
- With macro defined, retire 2^CNT_W instructions (CNT_W=4 → 16 instructions) → `instr_count` wraps to 0. Without the macro, `instr_count` stays 0.
